rcc_rst_seq: RTL

RCC_RST_SEQ -- requirements
Module: rcc_rst_seq

---
 rtl/rcc_rst_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rcc_rst_seq.sv
// rtl/rcc_rst_seq.sv - PLL-qualified staged domain reset release with APB software resets (optional RCC_WDT_RST_EN)
module rcc_rst_seq #(
    parameter int LOCK_CNT  = 16,
    parameter int STAGE_GAP = 4,
    parameter int SW_PULSE  = 8
) (
    input  logic        module_clk,
    input  logic        module_rstn,
    input  logic        pll_locked,
`ifdef RCC_WDT_RST_EN
    input  logic        wdt_rst_req,
`endif
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        sys_rstn,
    output logic        apb0_rstn,
    output logic        apb1_rstn,
    output logic        apb2_rstn,
    output logic        eth_pe_tx_rstn,
    output logic        eth_pe_rx_rstn,
    output logic        advtim_pe_rstn,
    output logic        seq_done
);

    // Encoded in release order so "released" tests are simple compares.
    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] REL_SYS   = 3'd2;
    localparam logic [2:0] REL_APB   = 3'd3;
    localparam logic [2:0] REL_ETH   = 3'd4;
    localparam logic [2:0] REL_ADV   = 3'd5;
    localparam logic [2:0] RUN       = 3'd6;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);
    localparam logic [7:0] SW_LEN    = 8'(SW_PULSE);

    logic [2:0]      state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [3:0][7:0] pcnt, pcnt_nxt;   // apb1, apb2, eth, advtim
    logic [3:0]      pulse_act;
    logic            unlock_flg;
    logic            wdt_flg;
    logic            wr_acc, ctrl_wr, stat_wr, restart;
    logic            unused_bits;

    assign wr_acc  = psel & penable & pwrite;
    assign ctrl_wr = wr_acc & (paddr[7:0] == 8'h00);
    assign stat_wr = wr_acc & (paddr[7:0] == 8'h04);

`ifdef RCC_WDT_RST_EN
    assign restart = (ctrl_wr & pwdata[8]) | wdt_rst_req;
`else
    assign restart = ctrl_wr & pwdata[8];
`endif

    assign unused_bits = ^{paddr[31:8], pwdata[31:10], pwdata[7:4]};

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            pulse_act[d] = (pcnt[d] != 8'd0);
        end
    end

    // Sequencer next state: loss of lock or a restart always wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!pll_locked || restart) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state_nxt = STABLE;
                    cnt_nxt   = 8'd0;
                end
                STABLE: begin
                    if (cnt == LOCK_LAST) begin
                        state_nxt = REL_SYS;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                REL_SYS, REL_APB, REL_ETH: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = state + 3'd1;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                // advtim is released on entry here; one cycle later we settle in RUN.
                REL_ADV: state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // Software pulse counters: accepted only in RUN, restarted on rewrite, killed by unlock/restart.
    always_comb begin
        pcnt_nxt = pcnt;
        for (int d = 0; d < 4; d++) begin
            if (!pll_locked || restart) begin
                pcnt_nxt[d] = 8'd0;
            end else if (ctrl_wr && (state == RUN) && pwdata[d]) begin
                pcnt_nxt[d] = SW_LEN;
            end else if (pcnt[d] != 8'd0) begin
                pcnt_nxt[d] = pcnt[d] - 8'd1;
            end
        end
    end

    // State, counters, unlock flag and registered reset outputs.
    always_ff @(posedge module_clk) begin
        if (!module_rstn) begin
            state          <= WAIT_LOCK;
            cnt            <= 8'd0;
            pcnt           <= '0;
            unlock_flg     <= 1'b0;
            sys_rstn       <= 1'b0;
            apb0_rstn      <= 1'b0;
            apb1_rstn      <= 1'b0;
            apb2_rstn      <= 1'b0;
            eth_pe_tx_rstn <= 1'b0;
            eth_pe_rx_rstn <= 1'b0;
            advtim_pe_rstn <= 1'b0;
            seq_done       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pcnt  <= pcnt_nxt;
            if (!pll_locked && (state != WAIT_LOCK)) begin
                unlock_flg <= 1'b1;
            end else if (stat_wr && pwdata[9]) begin
                unlock_flg <= 1'b0;
            end
            sys_rstn       <= (state_nxt >= REL_SYS);
            apb0_rstn      <= (state_nxt >= REL_SYS);
            apb1_rstn      <= (state_nxt >= REL_APB) && (pcnt_nxt[0] == 8'd0);
            apb2_rstn      <= (state_nxt >= REL_APB) && (pcnt_nxt[1] == 8'd0);
            eth_pe_tx_rstn <= (state_nxt >= REL_ETH) && (pcnt_nxt[2] == 8'd0);
            eth_pe_rx_rstn <= (state_nxt >= REL_ETH) && (pcnt_nxt[2] == 8'd0);
            advtim_pe_rstn <= (state_nxt >= REL_ADV) && (pcnt_nxt[3] == 8'd0);
            seq_done       <= (state_nxt >= REL_ADV);
        end
    end

`ifdef RCC_WDT_RST_EN
    // Watchdog flag survives restarts; only module reset or W1C clears it, and set beats clear.
    always_ff @(posedge module_clk) begin
        if (!module_rstn) begin
            wdt_flg <= 1'b0;
        end else if (wdt_rst_req) begin
            wdt_flg <= 1'b1;
        end else if (stat_wr && pwdata[8]) begin
            wdt_flg <= 1'b0;
        end
    end
`else
    assign wdt_flg = 1'b0;
`endif

    // Combinational read mux; CTRL and unmapped addresses read zero.
    always_comb begin
        prdata = 32'd0;
        if (module_rstn && psel && !pwrite && (paddr[7:0] == 8'h04)) begin
            prdata = {22'd0, unlock_flg, wdt_flg, pulse_act, 2'b00, seq_done, pll_locked};
        end
    end

endmodule
